// File: rtl/adr_regfile_sb_if.sv
// Bus bundle for adr_regfile_sb: read ports, issue handshake, writeback port
// and busy count. The register file uses the slave side.
interface adr_regfile_sb_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2
);
   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NREGS + 1);

   logic [NREAD*AW-1:0]   rd_addr_i;
   logic [NREAD*XLEN-1:0] rd_data_o;
   logic [NREAD-1:0]      rd_busy_o;
   logic                  iss_valid_i;
   logic [AW-1:0]         iss_addr_i;
   logic                  iss_ready_o;
   logic                  wr_en_i;
   logic [AW-1:0]         wr_addr_i;
   logic [XLEN-1:0]       wr_data_i;
   logic [CW-1:0]         busy_count_o;

   modport master (
      output rd_addr_i, iss_valid_i, iss_addr_i, wr_en_i, wr_addr_i, wr_data_i,
      input  rd_data_o, rd_busy_o, iss_ready_o, busy_count_o
   );

   modport slave (
      input  rd_addr_i, iss_valid_i, iss_addr_i, wr_en_i, wr_addr_i, wr_data_i,
      output rd_data_o, rd_busy_o, iss_ready_o, busy_count_o
   );
endinterface

// File: rtl/adr_regfile_sb.sv
// Architectural register file with NREAD combinational read ports, one
// writeback port, optional write-to-read bypass and a busy-bit scoreboard.
module adr_regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1
) (
   input logic            clk,
   input logic            reset,
   adr_regfile_sb_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NREGS + 1);

   logic [XLEN-1:0]  regs_q [1:NREGS-1];
   logic [NREGS-1:1] busy_q;
   logic [NREGS-1:1] busy_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             iss_ready_s;
   logic             iss_acc_s;

   function automatic logic busy_at(input logic [NREGS-1:1] v, input logic [AW-1:0] a);
      return (a == '0) ? 1'b0 : v[a];
   endfunction

   function automatic logic [CW-1:0] popcount(input logic [NREGS-1:1] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 1; i < NREGS; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // A writeback to the same register frees the slot in the same cycle.
   always_comb begin
      iss_ready_s = (bus.iss_addr_i == '0) || !busy_at(busy_q, bus.iss_addr_i) ||
                    (bus.wr_en_i && (bus.wr_addr_i == bus.iss_addr_i));
      iss_acc_s   = bus.iss_valid_i && iss_ready_s;
   end

   // Next busy vector: writeback clears, accepted issue sets (set wins).
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NREGS; i++) begin
         if (iss_acc_s && (bus.iss_addr_i == AW'(i))) begin
            busy_d[i] = 1'b1;
         end else if (bus.wr_en_i && (bus.wr_addr_i == AW'(i))) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
      count_d = popcount(busy_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (bus.wr_en_i && (bus.wr_addr_i == AW'(i))) begin
               regs_q[i] <= bus.wr_data_i;
            end
         end
      end
   end

   // Read ports; busy clear-bypass applies even when data bypass is off.
   always_comb begin
      bus.rd_data_o = '0;
      bus.rd_busy_o = '0;
      for (int k = 0; k < NREAD; k++) begin
         logic [AW-1:0] a;
         logic          hit;
         a   = bus.rd_addr_i[k*AW +: AW];
         hit = bus.wr_en_i && (bus.wr_addr_i == a);
         if (a == '0) begin
            bus.rd_data_o[k*XLEN +: XLEN] = '0;
         end else if ((BYPASS != 0) && hit) begin
            bus.rd_data_o[k*XLEN +: XLEN] = bus.wr_data_i;
         end else begin
            bus.rd_data_o[k*XLEN +: XLEN] = regs_q[a];
         end
         bus.rd_busy_o[k] = busy_at(busy_q, a) && !hit;
      end
   end

   assign bus.iss_ready_o  = iss_ready_s;
   assign bus.busy_count_o = count_q;
endmodule

// File: tb/tb_adr_regfile_sb.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share the same
// stimulus and are compared against an array/flag model of the register file.
module tb_adr_regfile_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NREAD = 2;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   adr_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_b1 ();
   adr_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_b0 ();

   adr_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut_b1 (
      .clk(clk), .reset(reset), .bus(bus_b1.slave)
   );
   adr_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_b0 (
      .clk(clk), .reset(reset), .bus(bus_b0.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] m_regs [32];
   bit          m_busy [32];
   int          c_ra [2];
   bit          c_iv;
   int          c_ia;
   bit          c_we;
   int          c_wa;
   logic [31:0] c_wd;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'd0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic bit model_ready();
      return (c_ia == 0) || !m_busy[c_ia] || (c_we && c_wa == c_ia);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string tag, input int bp, input logic [63:0] rdata,
                            input logic [1:0] rbusy, input logic rdy, input logic [5:0] cnt);
      for (int k = 0; k < 2; k++) begin
         int          a;
         bit          hit;
         logic [31:0] ed;
         a   = c_ra[k];
         hit = c_we && (c_wa == a);
         if (a == 0) ed = 32'd0;
         else if (bp == 1 && hit) ed = c_wd;
         else ed = m_regs[a];
         check_eq($sformatf("%s b%0d data%0d", tag, bp, k), rdata[k*32 +: 32], ed);
         check_eq($sformatf("%s b%0d busy%0d", tag, bp, k), 32'(rbusy[k]),
                  32'(a != 0 && m_busy[a] && !hit));
      end
      check_eq($sformatf("%s b%0d ready", tag, bp), 32'(rdy), 32'(model_ready()));
      check_eq($sformatf("%s b%0d count", tag, bp), 32'(cnt), 32'(model_count()));
   endtask

   task automatic check_both(input string tag);
      check_dut(tag, 1, bus_b1.rd_data_o, bus_b1.rd_busy_o, bus_b1.iss_ready_o, bus_b1.busy_count_o);
      check_dut(tag, 0, bus_b0.rd_data_o, bus_b0.rd_busy_o, bus_b0.iss_ready_o, bus_b0.busy_count_o);
   endtask

   task automatic drive(input int ra0, input int ra1, input bit iv, input int ia,
                        input bit we, input int wa, input logic [31:0] wd);
      c_ra[0] = ra0; c_ra[1] = ra1; c_iv = iv; c_ia = ia; c_we = we; c_wa = wa; c_wd = wd;
      bus_b1.rd_addr_i = {AW'(ra1), AW'(ra0)};
      bus_b0.rd_addr_i = {AW'(ra1), AW'(ra0)};
      bus_b1.iss_valid_i = iv;  bus_b0.iss_valid_i = iv;
      bus_b1.iss_addr_i = AW'(ia); bus_b0.iss_addr_i = AW'(ia);
      bus_b1.wr_en_i = we;      bus_b0.wr_en_i = we;
      bus_b1.wr_addr_i = AW'(wa); bus_b0.wr_addr_i = AW'(wa);
      bus_b1.wr_data_i = wd;    bus_b0.wr_data_i = wd;
   endtask

   // Drive, check mid-cycle, clock, then advance the model.
   task automatic cyc(input string tag, input int ra0, input int ra1, input bit iv, input int ia,
                      input bit we, input int wa, input logic [31:0] wd);
      bit rdy;
      drive(ra0, ra1, iv, ia, we, wa, wd);
      #2;
      check_both(tag);
      rdy = model_ready();
      @(posedge clk);
      if (we && wa != 0) begin
         m_regs[wa] = wd;
         m_busy[wa] = 1'b0;
      end
      if (iv && rdy && ia != 0) m_busy[ia] = 1'b1;
      #1;
   endtask

   initial begin
      model_reset();
      drive(5, 17, 1'b0, 3, 1'b0, 0, 32'd0);
      #3;
      check_both("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int a = 0; a < 32; a++) cyc("rst_read", a, 31 - a, 1'b0, a, 1'b0, 0, 32'd0);

      cyc("wr_r5", 0, 0, 1'b0, 0, 1'b1, 5, 32'hDEADBEEF);
      cyc("rd_r5", 5, 5, 1'b0, 0, 1'b0, 0, 32'd0);
      check_eq("r5_direct", bus_b1.rd_data_o[31:0], 32'hDEADBEEF);
      cyc("wr_r0", 0, 0, 1'b0, 0, 1'b1, 0, 32'h1234);
      cyc("rd_r0", 0, 0, 1'b0, 0, 1'b0, 0, 32'd0);

      cyc("wr_r7_old", 0, 0, 1'b0, 0, 1'b1, 7, 32'h11111111);
      drive(7, 7, 1'b0, 0, 1'b1, 7, 32'hA5A5A5A5);
      #2;
      check_eq("byp1_same", bus_b1.rd_data_o[31:0], 32'hA5A5A5A5);
      check_eq("byp0_same", bus_b0.rd_data_o[31:0], 32'h11111111);
      cyc("byp_r7", 7, 7, 1'b0, 0, 1'b1, 7, 32'hA5A5A5A5);
      cyc("byp_r7_next", 7, 0, 1'b0, 0, 1'b0, 0, 32'd0);

      cyc("iss_r3", 3, 0, 1'b1, 3, 1'b0, 0, 32'd0);
      drive(3, 3, 1'b1, 3, 1'b0, 0, 32'd0);
      #2;
      check_eq("r3_busy", 32'(bus_b1.rd_busy_o[0]), 32'd1);
      check_eq("r3_count", 32'(bus_b1.busy_count_o), 32'd1);
      check_eq("r3_reiss_ready", 32'(bus_b1.iss_ready_o), 32'd0);
      cyc("reiss_r3", 3, 3, 1'b1, 3, 1'b0, 0, 32'd0);
      cyc("reiss_wb_r3", 3, 3, 1'b1, 3, 1'b1, 3, 32'h33);
      cyc("after_wb_r3", 3, 0, 1'b0, 0, 1'b0, 0, 32'd0);
      check_eq("r3_setwins_count", 32'(bus_b1.busy_count_o), 32'd1);

      for (int a = 1; a < 32; a++) cyc("iss_all", a, a - 1, 1'b1, a, 1'b0, 0, 32'd0);
      check_eq("count31", 32'(bus_b0.busy_count_o), 32'd31);
      for (int a = 1; a < 32; a++) cyc("wb_all", a, 31 - a, 1'b0, 0, 1'b1, a, $urandom);
      check_eq("count0", 32'(bus_b1.busy_count_o), 32'd0);
      cyc("iss_r0", 0, 0, 1'b1, 0, 1'b0, 0, 32'd0);
      check_eq("iss_r0_count", 32'(bus_b1.busy_count_o), 32'd0);

      for (int n = 0; n < 400; n++) begin
         cyc("rand", $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
             $urandom_range(0, 31), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 31), $urandom);
      end

      for (int a = 1; a < 32; a++) cyc("clr_all", a, 0, 1'b0, 0, 1'b1, a, 32'h100 + 32'(a));
      cyc("iss2", 0, 0, 1'b1, 2, 1'b0, 0, 32'd0);
      cyc("iss4", 0, 0, 1'b1, 4, 1'b0, 0, 32'd0);
      cyc("iss6", 0, 0, 1'b1, 6, 1'b0, 0, 32'd0);
      cyc("iss8", 2, 4, 1'b1, 8, 1'b0, 0, 32'd0);
      check_eq("pre_rst_count", 32'(bus_b1.busy_count_o), 32'd4);
      drive(2, 4, 1'b0, 6, 1'b1, 9, 32'hCAFEF00D);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_both("async_rst");
      check_eq("async_rst_count", 32'(bus_b0.busy_count_o), 32'd0);
      @(posedge clk);
      #1;
      drive(9, 6, 1'b0, 8, 1'b0, 0, 32'd0);
      #2;
      check_both("rst_hold");
      reset = 1'b0;
      #1;
      cyc("post_rst", 9, 8, 1'b0, 2, 1'b0, 0, 32'd0);
      cyc("post_rst2", 2, 4, 1'b0, 0, 1'b0, 0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
